audio_event_sequencer: RTL and testbench

Converts raw game events (key press, ball-into-hole, ball-to-border collision) into timed, mutually exclusive audio request lines that drive the tone decoder's `keyAudioRequest`, `holeColAudioRequest` and `borderColAudioRequest` inputs. Each event sounds for a fixed per-source duration. Events are prioritised, can preempt, and are queued one-deep per source with a silent gap between consecutive sounds. The block sits between the game-logic/keypad layer and the tone decoder/tone generator chain.

---
 rtl/audio_event_sequencer.sv | 152 +++++++++++++++
 tb/tb_audio_event_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_event_sequencer.sv
// Turns edge-triggered game events into timed, prioritised, mutually exclusive
// audio request lines (hole > border > key) with one-deep queuing and a silent gap.
module audio_event_sequencer #(
  parameter int CLK_HZ    = 25_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int KEY_MS    = 100,
  parameter int HOLE_MS   = 400,
  parameter int BORDER_MS = 150,
  parameter int GAP_MS    = 20
) (
  input  logic clk,
  input  logic resetN,
  input  logic enable,
  input  logic keyEvent,
  input  logic holeColEvent,
  input  logic borderColEvent,
  output logic keyAudioRequest,
  output logic holeColAudioRequest,
  output logic borderColAudioRequest,
  output logic busy
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [15:0] KEY_LEN    = 16'(KEY_MS);
  localparam logic [15:0] HOLE_LEN   = 16'(HOLE_MS);
  localparam logic [15:0] BORDER_LEN = 16'(BORDER_MS);
  localparam logic [15:0] GAP_LEN    = 16'(GAP_MS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  // Sources are one-hot with bit index == priority: [2] hole, [1] border, [0] key,
  // so numeric comparison of two one-hot codes is a priority comparison.
  logic [2:0]    evIn, evReg, evPrev, trig;
  logic [1:0]    state, nState;
  logic [2:0]    cur, nCur, pend, nPend, trigTop, pendTop;
  logic [PW-1:0] presc;
  logic [15:0]   dur, loadVal;
  logic          load, tick, expire, busyR;

  function automatic logic [2:0] highest(input logic [2:0] v);
    if (v[2])      return 3'b100;
    else if (v[1]) return 3'b010;
    else if (v[0]) return 3'b001;
    else           return 3'b000;
  endfunction

  function automatic logic [15:0] lenOf(input logic [2:0] s);
    case (s)
      3'b100:  return HOLE_LEN;
      3'b010:  return BORDER_LEN;
      default: return KEY_LEN;
    endcase
  endfunction

  assign evIn    = {holeColEvent, borderColEvent, keyEvent};
  assign trig    = enable ? (evReg & ~evPrev) : 3'b000;
  assign tick    = (presc == PMAX);
  assign expire  = tick && (dur == 16'd1);
  assign trigTop = highest(trig);
  assign pendTop = highest(pend | trig);

  always_comb begin
    nState  = state;
    nCur    = cur;
    nPend   = pend | trig;
    load    = 1'b0;
    loadVal = GAP_LEN;
    case (state)
      IDLE: if (trig != 3'b000) begin
        nState = PLAY;
        nCur   = trigTop;
        load   = 1'b1;
      end
      PLAY: begin
        // Preemption wins over expiry in the same cycle.
        if (trig != 3'b000 && trigTop >= cur) begin
          nCur = trigTop;
          load = 1'b1;
        end else if (expire) begin
          if (nPend == 3'b000) begin
            nState = IDLE;
            nCur   = 3'b000;
          end else if (GAP_MS > 0) begin
            nState = GAP;
            nCur   = 3'b000;
            load   = 1'b1;
          end else begin
            nCur = pendTop;
            load = 1'b1;
          end
        end
      end
      GAP: if (expire) begin
        load   = (nPend != 3'b000);
        nState = load ? PLAY : IDLE;
        nCur   = pendTop;
      end
      default: begin
        nState = IDLE;
        nCur   = 3'b000;
      end
    endcase
    if (load && nState == PLAY) loadVal = lenOf(nCur);
    if (load) nPend = nPend & ~nCur;
    if (!enable) begin
      nState = IDLE;
      nCur   = 3'b000;
      nPend  = 3'b000;
      load   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      evReg  <= '0;
      evPrev <= '0;
      state  <= IDLE;
      cur    <= '0;
      pend   <= '0;
      presc  <= '0;
      dur    <= '0;
      busyR  <= 1'b0;
    end else begin
      evReg  <= evIn;
      evPrev <= evReg;
      state  <= nState;
      cur    <= nCur;
      pend   <= nPend;
      busyR  <= (nState != IDLE);
      if (load) begin
        presc <= '0;
        dur   <= loadVal;
      end else if (nState == IDLE) begin
        presc <= '0;
        dur   <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) dur <= dur - 16'd1;
      end
    end
  end

  assign keyAudioRequest       = cur[0];
  assign borderColAudioRequest = cur[1];
  assign holeColAudioRequest   = cur[2];
  assign busy                  = busyR;

endmodule

// File: tb/tb_audio_event_sequencer.sv
// Bench for audio_event_sequencer: segment scoreboard on the GAP_MS=2 instance,
// hand-written sequences for zero-gap handover, mute and async reset.
module tb_audio_event_sequencer;

  logic clk = 1'b0;
  logic resetN, enable, keyEvent, holeColEvent, borderColEvent;
  logic key0, hole0, bor0, busy0;
  logic key1, hole1, bor1, busy1;

  always #5 clk = ~clk;

  audio_event_sequencer #(.CLK_HZ(1000), .TICK_HZ(100), .KEY_MS(3), .HOLE_MS(5),
    .BORDER_MS(4), .GAP_MS(2)) dut0 (
    .clk(clk), .resetN(resetN), .enable(enable), .keyEvent(keyEvent),
    .holeColEvent(holeColEvent), .borderColEvent(borderColEvent),
    .keyAudioRequest(key0), .holeColAudioRequest(hole0),
    .borderColAudioRequest(bor0), .busy(busy0));

  audio_event_sequencer #(.CLK_HZ(1000), .TICK_HZ(100), .KEY_MS(3), .HOLE_MS(5),
    .BORDER_MS(4), .GAP_MS(0)) dut1 (
    .clk(clk), .resetN(resetN), .enable(enable), .keyEvent(keyEvent),
    .holeColEvent(holeColEvent), .borderColEvent(borderColEvent),
    .keyAudioRequest(key1), .holeColAudioRequest(hole1),
    .borderColAudioRequest(bor1), .busy(busy1));

  // Signature {busy, hole, border, key}
  localparam logic [3:0] K = 4'b1001, B = 4'b1010, H = 4'b1100, G = 4'b1000, Z = 4'b0000;

  typedef struct packed {
    logic [3:0] code;
    logic [7:0] len;
  } seg_t;

  typedef struct packed {
    logic [2:0]       ev1;
    logic [7:0]       d;
    logic [2:0]       ev2;
    logic [2:0]       n;
    logic [4:0][3:0]  code;
    logic [4:0][7:0]  len;
  } vec_t;

  seg_t sb[$];
  int   checks = 0, errors = 0;
  logic monOn = 1'b0;
  logic [3:0] prevSig, sig;
  int   runLen;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setEv(input logic [2:0] m);
    {holeColEvent, borderColEvent, keyEvent} = m;
  endtask

  // Measures each busy run of constant signature and compares against the scoreboard.
  always @(negedge clk) begin
    if (!monOn) begin
      prevSig = Z;
      runLen  = 0;
    end else begin
      sig = {busy0, hole0, bor0, key0};
      checks++;
      if ($countones(sig[2:0]) > 1 || (sig[2:0] != 3'b000 && !sig[3])) begin
        errors++;
        $display("FAIL exclusive: got %b", sig);
      end
      if (sig == prevSig) runLen++;
      else begin
        if (prevSig[3]) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL segment: got %b x %0d expected none", prevSig, runLen);
          end else begin
            seg_t e;
            e = sb.pop_front();
            if (e.code != prevSig || int'(e.len) != runLen) begin
              errors++;
              $display("FAIL segment: got %b x %0d expected %b x %0d",
                       prevSig, runLen, e.code, e.len);
            end
          end
        end
        prevSig = sig;
        runLen  = 1;
      end
    end
  end

  function automatic vec_t mk(input logic [2:0] e1, input int d, input logic [2:0] e2,
                              input int n, input logic [19:0] c, input logic [39:0] l);
    vec_t v;
    v.ev1 = e1; v.d = 8'(d); v.ev2 = e2; v.n = 3'(n);
    v.code = c; v.len = l;
    return v;
  endfunction

  task automatic drain(input string nm);
    for (int c = 0; c < 2000; c++) begin
      cycle();
      if (sb.size() == 0 && !busy0) break;
    end
    repeat (3) cycle();
    chk(nm, sb.size(), 0);
    sb.delete();
  endtask

  vec_t tbl[7];
  seg_t s;
  int holeCnt, keyCnt, gapCnt, firstKey, lastHole, busyCnt;

  initial begin
    tbl[0] = mk(3'b001, 1, 3'b000, 1, {Z, Z, Z, Z, K}, {8'd0, 8'd0, 8'd0, 8'd0, 8'd30});
    tbl[1] = mk(3'b010, 1, 3'b000, 1, {Z, Z, Z, Z, B}, {8'd0, 8'd0, 8'd0, 8'd0, 8'd40});
    tbl[2] = mk(3'b001, 5, 3'b100, 2, {Z, Z, Z, H, K}, {8'd0, 8'd0, 8'd0, 8'd50, 8'd5});
    tbl[3] = mk(3'b100, 10, 3'b001, 3, {Z, Z, K, G, H}, {8'd0, 8'd0, 8'd30, 8'd20, 8'd50});
    tbl[4] = mk(3'b111, 1, 3'b000, 5, {K, G, B, G, H}, {8'd30, 8'd20, 8'd40, 8'd20, 8'd50});
    tbl[5] = mk(3'b001, 3, 3'b010, 2, {Z, Z, Z, B, K}, {8'd0, 8'd0, 8'd0, 8'd40, 8'd3});
    tbl[6] = mk(3'b010, 5, 3'b001, 3, {Z, Z, K, G, B}, {8'd0, 8'd0, 8'd30, 8'd20, 8'd40});

    resetN = 1'b0; enable = 1'b1; setEv(3'b000);
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;

    // Idle after reset
    for (int i = 0; i < 50; i++) begin
      cycle();
      chk("idle0", {busy0, hole0, bor0, key0}, 0);
      chk("idle1", {busy1, hole1, bor1, key1}, 0);
    end

    // Table-driven pulse scenarios
    monOn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < int'(tbl[i].n); j++) begin
        s.code = tbl[i].code[j];
        s.len  = tbl[i].len[j];
        sb.push_back(s);
      end
      setEv(tbl[i].ev1);
      for (int k = 0; k < int'(tbl[i].d); k++) begin
        cycle();
        setEv(3'b000);
      end
      setEv(tbl[i].ev2);
      cycle();
      setEv(3'b000);
      drain($sformatf("vec%0d_drain", i));
    end

    // Held level gives one sound
    s.code = B; s.len = 8'd40; sb.push_back(s);
    borderColEvent = 1'b1;
    repeat (200) cycle();
    borderColEvent = 1'b0;
    drain("held_border");
    monOn = 1'b0;
    repeat (5) cycle();

    // Zero-gap instance: hole then key back-to-back
    holeCnt = 0; keyCnt = 0; gapCnt = 0; firstKey = -1; lastHole = -1;
    for (int k = 0; k < 120; k++) begin
      holeColEvent = (k == 0);
      keyEvent     = (k == 10);
      cycle();
      if (hole1) begin holeCnt++; lastHole = k; end
      if (key1) begin keyCnt++; if (firstKey < 0) firstKey = k; end
      if (busy1 && !hole1 && !key1 && !bor1) gapCnt++;
    end
    setEv(3'b000);
    chk("nogap_hole_len", holeCnt, 50);
    chk("nogap_key_len", keyCnt, 30);
    chk("nogap_gap", gapCnt, 0);
    chk("nogap_handover", firstKey, lastHole + 1);
    chk("nogap_idle", {busy1, hole1, bor1, key1}, 0);

    // Mute mid-play with key pending, then re-enable with key held high
    holeColEvent = 1'b1; cycle(); holeColEvent = 1'b0;
    repeat (4) cycle();
    keyEvent = 1'b1; cycle(); keyEvent = 1'b0;
    repeat (14) cycle();
    chk("pre_mute", {busy0, hole0, bor0, key0}, 4'b1100);
    enable = 1'b0;
    cycle();
    chk("mute", {busy0, hole0, bor0, key0}, 0);
    keyEvent = 1'b1;
    repeat (10) cycle();
    enable = 1'b1;
    busyCnt = 0;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (busy0 || key0) busyCnt++;
    end
    chk("after_mute", busyCnt, 0);
    keyEvent = 1'b0;
    repeat (5) cycle();

    // Asynchronous reset mid-play
    keyEvent = 1'b1; cycle(); keyEvent = 1'b0;
    repeat (10) cycle();
    chk("pre_reset", {busy0, hole0, bor0, key0}, 4'b1001);
    #2 resetN = 1'b0;
    #1 chk("async_reset", {busy0, hole0, bor0, key0}, 0);
    repeat (2) cycle();
    resetN = 1'b1;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
